// File: rtl/uart_tx_pkg.sv
// Shared types for the UART transmitter.
//   state_t        : encoding of the transmit FSM state. It is exported on the
//                    current_state port so that an external serial-line
//                    selector can decode it.
//   LAST_BIT_INDEX : index of the final data bit (8 data bits, LSB first).
package uart_tx_pkg;

  typedef enum logic [2:0] {
    s_IDLE         = 3'd0,
    s_TX_START_BIT = 3'd1,
    s_TX_DATA_BITS = 3'd2,
    s_TX_STOP_BIT  = 3'd3,
    s_CLEANUP      = 3'd4
  } state_t;

  localparam logic [2:0] LAST_BIT_INDEX = 3'd7;

endpackage

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter.
//   i_Clock    : system clock
//   i_Rst_n    : asynchronous reset, active-low
//   clear      : synchronous clear of the period counter
//   enable     : count while high
//   period_end : high during the last cycle (CLKS_PER_BIT-1) of a bit period
// The counter runs 0..CLKS_PER_BIT-1. It wraps to 0 on its own at the end of
// each period, so back-to-back bit periods need no extra clear.
module uart_tx_bit_timer #(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic i_Clock,
  input  logic i_Rst_n,
  input  logic clear,
  input  logic enable,
  output logic period_end
);

  localparam int W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);

  logic [W-1:0] count;

  assign period_end = enable && (count == LAST);

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= period_end ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/uart_tx_fsm.sv
// UART transmit sequencer: start bit, 8 data bits (LSB first), stop bit.
//   i_Clock       : system clock
//   i_Rst_n       : asynchronous reset, active-low
//   i_Tx_DV       : request strobe; it is honoured only in s_IDLE
//   i_Tx_Byte     : byte to send; it is latched when the request is accepted
//   current_state : registered FSM state
//   bit_index     : data bit currently on the line
//   o_Tx_Byte     : latched byte; it holds steady for the whole frame
//   o_Tx_Active   : high while a frame is on the line
//   o_Tx_Done     : single-cycle pulse that is high in s_CLEANUP
//
// state          | meaning
// s_IDLE         | line idle; waiting for i_Tx_DV
// s_TX_START_BIT | start bit, lasts one bit period
// s_TX_DATA_BITS | data bits 0..7, one bit period each
// s_TX_STOP_BIT  | stop bit, lasts one bit period
// s_CLEANUP      | one cycle; o_Tx_Done is asserted
module uart_tx_fsm
  import uart_tx_pkg::*;
#(
  parameter int CLKS_PER_BIT = 87
) (
  input  logic       i_Clock,
  input  logic       i_Rst_n,
  input  logic       i_Tx_DV,
  input  logic [7:0] i_Tx_Byte,
  output state_t     current_state,
  output logic [2:0] bit_index,
  output logic [7:0] o_Tx_Byte,
  output logic       o_Tx_Active,
  output logic       o_Tx_Done
);

  state_t     next_state;
  logic [2:0] bit_index_nxt;
  logic [7:0] tx_byte_nxt;
  logic       active_nxt;
  logic       done_nxt;
  logic       timer_en;
  logic       period_end;

  // The timer runs only in the three timed states. It is held clear in
  // s_IDLE and s_CLEANUP, so every timed state starts counting from 0.
  assign timer_en = (current_state == s_TX_START_BIT) ||
                    (current_state == s_TX_DATA_BITS) ||
                    (current_state == s_TX_STOP_BIT);

  uart_tx_bit_timer #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_bit_timer (
    .i_Clock   (i_Clock),
    .i_Rst_n   (i_Rst_n),
    .clear     (!timer_en),
    .enable    (timer_en),
    .period_end(period_end)
  );

  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      current_state <= s_IDLE;
      bit_index     <= 3'd0;
      o_Tx_Byte     <= 8'h00;
      o_Tx_Active   <= 1'b0;
      o_Tx_Done     <= 1'b0;
    end else begin
      current_state <= next_state;
      bit_index     <= bit_index_nxt;
      o_Tx_Byte     <= tx_byte_nxt;
      o_Tx_Active   <= active_nxt;
      o_Tx_Done     <= done_nxt;
    end
  end

  always_comb begin
    next_state    = current_state;
    bit_index_nxt = bit_index;
    tx_byte_nxt   = o_Tx_Byte;
    active_nxt    = o_Tx_Active;
    done_nxt      = 1'b0;

    case (current_state)
      s_IDLE: begin
        bit_index_nxt = 3'd0;
        active_nxt    = 1'b0;
        if (i_Tx_DV) begin
          tx_byte_nxt = i_Tx_Byte;
          active_nxt  = 1'b1;
          next_state  = s_TX_START_BIT;
        end
      end
      s_TX_START_BIT: begin
        if (period_end) begin
          bit_index_nxt = 3'd0;
          next_state    = s_TX_DATA_BITS;
        end
      end
      s_TX_DATA_BITS: begin
        if (period_end) begin
          if (bit_index < LAST_BIT_INDEX) begin
            bit_index_nxt = bit_index + 3'd1;
          end else begin
            bit_index_nxt = 3'd0;
            next_state    = s_TX_STOP_BIT;
          end
        end
      end
      s_TX_STOP_BIT: begin
        // Clear Active and raise Done on the same edge, so that Done
        // appears in s_CLEANUP.
        if (period_end) begin
          active_nxt = 1'b0;
          done_nxt   = 1'b1;
          next_state = s_CLEANUP;
        end
      end
      s_CLEANUP: begin
        next_state = s_IDLE;
      end
      default: begin
        next_state    = s_IDLE;
        bit_index_nxt = 3'd0;
        active_nxt    = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_uart_tx_fsm.sv
module tb_uart_tx_fsm;
  import uart_tx_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       dv;
  logic       which2;
  logic [7:0] byte_in;

  state_t     st_a, st_b;
  logic [2:0] bi_a, bi_b;
  logic [7:0] by_a, by_b;
  logic       ac_a, ac_b, dn_a, dn_b;

  int tests  = 0;
  int failed = 0;
  int cyc    = 0;
  int done_cycles[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  uart_tx_fsm #(.CLKS_PER_BIT(4)) dut4 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv & ~which2), .i_Tx_Byte(byte_in),
    .current_state(st_a), .bit_index(bi_a), .o_Tx_Byte(by_a),
    .o_Tx_Active(ac_a), .o_Tx_Done(dn_a)
  );

  uart_tx_fsm #(.CLKS_PER_BIT(2)) dut2 (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv & which2), .i_Tx_Byte(byte_in),
    .current_state(st_b), .bit_index(bi_b), .o_Tx_Byte(by_b),
    .o_Tx_Active(ac_b), .o_Tx_Done(dn_b)
  );

  wire [2:0] st_o = which2 ? st_b : st_a;
  wire [2:0] bi_o = which2 ? bi_b : bi_a;
  wire [7:0] by_o = which2 ? by_b : by_a;
  wire       ac_o = which2 ? ac_b : ac_a;
  wire       dn_o = which2 ? dn_b : dn_a;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_idle(input string tag, input logic [7:0] exp_byte);
    chk({tag, "_state"}, st_o, 0);
    chk({tag, "_bit_index"}, bi_o, 0);
    chk({tag, "_active"}, ac_o, 0);
    chk({tag, "_done"}, dn_o, 0);
    chk({tag, "_byte"}, by_o, exp_byte);
  endtask

  // The model for one frame is worked out from cycle arithmetic. Cycle k
  // after the accepting edge falls in bit slot (k-1)/C: slot 0 is the start
  // bit, slots 1..8 are the data bits, and slot 9 is the stop bit. After
  // that come one CLEANUP cycle and one IDLE cycle.
  task automatic frame(input logic [7:0] b, input bit hold, input int inj_k);
    int c = which2 ? 2 : 4;
    int n_done = 0;
    int ph, es, eb, ea, ed;
    dv = 1'b1;
    byte_in = b;
    @(posedge clk);
    for (int k = 1; k <= 10 * c + 2; k++) begin
      @(negedge clk);
      if (k <= 10 * c) begin
        ph = (k - 1) / c;
        es = (ph == 0) ? 1 : ((ph <= 8) ? 2 : 3);
        eb = (ph >= 1 && ph <= 8) ? ph - 1 : 0;
        ea = 1;
        ed = 0;
      end else if (k == 10 * c + 1) begin
        es = 4; eb = 0; ea = 0; ed = 1;
      end else begin
        es = 0; eb = 0; ea = 0; ed = 0;
      end
      chk("frame_state", st_o, es);
      chk("frame_bit_index", bi_o, eb);
      chk("frame_active", ac_o, ea);
      chk("frame_done", dn_o, ed);
      chk("frame_byte", by_o, b);
      if (dn_o === 1'b1) begin
        n_done++;
        done_cycles.push_back(cyc);
      end
      if (hold) begin
        dv = 1'b1;
      end else if (k == inj_k) begin
        dv = 1'b1;
        byte_in = 8'h3C;
      end else begin
        dv = 1'b0;
        byte_in = 8'($urandom);
      end
    end
    chk("frame_done_count", n_done, 1);
  endtask

  initial begin
    logic [7:0] rb;
    int c, d0, d1;
    int n_done;
    rst_n = 1'b0;
    dv = 1'b0;
    byte_in = 8'h00;
    which2 = 1'b0;

    repeat (2) @(negedge clk);
    chk_idle("reset4", 8'h00);
    which2 = 1'b1;
    #1;
    chk_idle("reset2", 8'h00);
    which2 = 1'b0;

    @(negedge clk);
    rst_n = 1'b1;
    byte_in = 8'h77;
    repeat (2) begin
      @(negedge clk);
      chk_idle("idle_no_dv", 8'h00);
    end

    // Basic frame carrying 0xA5.
    frame(8'hA5, 1'b0, 0);
    // Same byte, with a request for 0x3C made in DATA; it must be ignored.
    frame(8'hA5, 1'b0, 10);
    // Random bytes, each with an ignored request at a random DATA cycle.
    repeat (3) begin
      rb = 8'($urandom);
      frame(rb, 1'b0, int'($urandom_range(4 + 1, 36)));
    end

    // Request held high: back-to-back frames with 0x00 and then 0xFF.
    done_cycles.delete();
    frame(8'h00, 1'b1, 0);
    frame(8'hFF, 1'b0, 0);
    if (done_cycles.size() == 2) begin
      d0 = done_cycles[0];
      d1 = done_cycles[1];
      chk("done_spacing", d1 - d0, 10 * 4 + 2);
    end else begin
      chk("done_pulses_held", done_cycles.size(), 2);
    end

    // Mid-frame reset applied while bit_index is 3.
    c = 4;
    rb = 8'($urandom) | 8'h01;
    dv = 1'b1;
    byte_in = rb;
    @(posedge clk);
    for (int k = 1; k <= 4 * c + 1; k++) begin
      @(negedge clk);
      dv = 1'b0;
    end
    chk("pre_abort_bit_index", bi_o, 3);
    chk("pre_abort_byte", by_o, rb);
    rst_n = 1'b0;
    #1;
    chk_idle("abort", 8'h00);
    n_done = 0;
    repeat (3) begin
      @(negedge clk);
      if (dn_o === 1'b1) n_done++;
    end
    rst_n = 1'b1;
    repeat (12 * c) begin
      @(negedge clk);
      if (dn_o === 1'b1) n_done++;
    end
    chk("abort_no_done", n_done, 0);
    chk_idle("post_abort", 8'h00);

    // The first edge that sees a request after reset accepts it.
    rb = 8'($urandom);
    frame(rb, 1'b0, 0);

    // Second instance, with a bit period of 2 cycles.
    which2 = 1'b1;
    #1;
    chk_idle("idle2", 8'h00);
    frame(8'h01, 1'b0, 0);
    rb = 8'($urandom);
    frame(rb, 1'b0, int'($urandom_range(3, 18)));

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/uart_tx_fsm.md
UART_TX_FSM -- requirements
Module: uart_tx_fsm

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 87, meaning clock cycles per serial bit (10 MHz / 115200 baud); legal range >= 2.
REQ-002 SHALL have port i_Clock  input  1  single system clock; all state is updated on its rising edge.
REQ-003 SHALL have port i_Rst_n  input  1  asynchronous reset, active-low.
REQ-004 SHALL have port i_Tx_DV  input  1  data-valid strobe; requests transmission of i_Tx_Byte.
REQ-005 SHALL have port i_Tx_Byte  input  8  byte to transmit, sampled when the request is accepted.
REQ-006 SHALL have port current_state  output  3  registered FSM state (uart_tx_pkg::state_t), drives the TX serial-output selector.
REQ-007 SHALL have port bit_index  output  3  index of the data bit currently on the line, LSB first.
REQ-008 SHALL have port o_Tx_Byte  output  8  latched copy of the accepted byte, stable for the whole frame.
REQ-009 SHALL have port o_Tx_Active  output  1  high while a frame is on the line.
REQ-010 SHALL have port o_Tx_Done  output  1  one-cycle completion pulse.

Function
REQ-011 SHALL implement states s_IDLE, s_TX_START_BIT, s_TX_DATA_BITS, s_TX_STOP_BIT, s_CLEANUP; no other reachable states.
REQ-012 SHALL keep a bit-period counter of width $clog2(CLKS_PER_BIT), counting 0..CLKS_PER_BIT-1 within START, each DATA bit and STOP, cleared on every state change and on every DATA bit boundary.
REQ-013 s_IDLE: counter = 0, bit_index = 0, o_Tx_Active = 0; if i_Tx_DV = 1 at an edge, latch i_Tx_Byte into o_Tx_Byte, set o_Tx_Active = 1, go to s_TX_START_BIT.
REQ-014 s_TX_START_BIT: occupy exactly CLKS_PER_BIT cycles, then go to s_TX_DATA_BITS with bit_index = 0.
REQ-015 s_TX_DATA_BITS: hold each bit_index for exactly CLKS_PER_BIT cycles; at period end increment bit_index if < 7, else wrap bit_index to 0 and go to s_TX_STOP_BIT.
REQ-016 s_TX_STOP_BIT: occupy exactly CLKS_PER_BIT cycles, then go to s_CLEANUP, clearing o_Tx_Active and setting o_Tx_Done on the same edge.
REQ-017 s_CLEANUP: one cycle; o_Tx_Done = 1 in this cycle only; next state s_IDLE.
REQ-018 Frame length SHALL be 10*CLKS_PER_BIT cycles (START+8 DATA+STOP) plus one CLEANUP cycle.
REQ-019 i_Tx_DV SHALL be ignored in every state except s_IDLE; o_Tx_Byte SHALL NOT change outside acceptance.
REQ-020 With i_Tx_DV held high continuously, next frame SHALL be accepted in the s_IDLE cycle following s_CLEANUP (no frames dropped, one idle cycle minimum between frames).
REQ-021 All outputs SHALL be registered; no combinational path from inputs to outputs.

Reset
REQ-022 On i_Rst_n = 0, asynchronously: current_state = s_IDLE, counter = 0, bit_index = 0, o_Tx_Byte = 8'h00, o_Tx_Active = 0, o_Tx_Done = 0.
REQ-023 Reset asserted mid-frame SHALL abort the frame immediately; no o_Tx_Done pulse for the aborted frame.
REQ-024 After release, first acceptance SHALL occur on the first rising edge with i_Tx_DV = 1.

Structure
REQ-025 state_t (3-bit enum, s_IDLE=0, s_TX_START_BIT=1, s_TX_DATA_BITS=2, s_TX_STOP_BIT=3, s_CLEANUP=4) SHALL reside in uart_tx_pkg and be imported, not redeclared.
REQ-026 Bit-period counting SHALL be a sub-module uart_tx_bit_timer (parameter CLKS_PER_BIT; inputs clear, enable; output period_end) instantiated once.

Verification (CLKS_PER_BIT = 4)
REQ-027 Reset, then i_Tx_DV pulse with 0xA5 at edge 0 -> START cycles 1-4, DATA cycles 5-36 (bit_index 0..7, 4 cycles each), STOP 37-40, CLEANUP with o_Tx_Done = 1 at cycle 41, IDLE at 42; o_Tx_Byte = 0xA5 throughout.
REQ-028 During frame 0xA5, pulse i_Tx_DV with 0x3C in DATA -> ignored; o_Tx_Byte stays 0xA5; exactly one o_Tx_Done pulse.
REQ-029 i_Tx_DV held high, bytes 0x00 then 0xFF -> second START begins cycle 43; two o_Tx_Done pulses 42 cycles apart.
REQ-030 Assert i_Rst_n = 0 at bit_index = 3 -> same-cycle current_state = s_IDLE, o_Tx_Active = 0, o_Tx_Byte = 0x00; no o_Tx_Done.
REQ-031 CLKS_PER_BIT = 2, byte 0x01 -> frame length 20 cycles + CLEANUP; counter never exceeds 1.
